// File: rtl/key_pkg.sv
// key_pkg: shared state encoding and counter-width helpers for the key conditioner
package key_pkg;
  typedef enum logic [1:0] {KS_IDLE, KS_DELAY, KS_REPEAT} key_state_t;
  localparam int MIN_W = 1;
  function automatic int cnt_w(input int n);
    return (n < 2) ? MIN_W : $clog2(n);
  endfunction
endpackage

// File: rtl/key_channel.sv
// key_channel: one key's synchroniser, debounce filter and hold-to-repeat pulse FSM
module key_channel
  import key_pkg::*;
#(
  parameter bit ACTIVE_LOW       = 1'b1,
  parameter int DEBOUNCE_CYC     = 1_000_000,
  parameter int REPEAT_DELAY_CYC = 25_000_000,
  parameter int REPEAT_RATE_CYC  = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic held,
  output logic pulse
);
  localparam int DW = cnt_w(DEBOUNCE_CYC);
  localparam int TMAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int TW = cnt_w(TMAX + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [TW-1:0] T_DELAY = TW'(REPEAT_DELAY_CYC);
  localparam logic [TW-1:0] T_RATE = TW'(REPEAT_RATE_CYC);
  logic pressed, s1, s2, stable, acc;
  logic [DW-1:0] cnt;
  logic [TW-1:0] timer, timer_nxt;
  key_state_t state, state_nxt;
  assign pressed = ACTIVE_LOW ? ~raw : raw;
  assign acc = (s2 != stable) && (cnt == D_LAST);
  // held is the level the stable register takes this edge, so the top's output
  // register lines up with it and pulse/held appear in the same cycle
  assign held = stable ^ acc;
  // two-flop synchroniser, reset to the released level
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pressed;
      s2 <= s1;
    end
  end
  // debounce: count consecutive cycles of disagreement, accept after the last one
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      cnt    <= (s2 == stable || acc) ? '0 : cnt + 1'b1;
      stable <= held;
    end
  end
  // repeat FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= KS_IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end
  // repeat FSM next state: timers count inclusively so a pulse is followed by N quiet cycles
  always_comb begin
    state_nxt = state;
    timer_nxt = '0;
    case (state)
      KS_IDLE:   state_nxt = held ? KS_DELAY : KS_IDLE;
      KS_DELAY: begin
        state_nxt = !held ? KS_IDLE : (timer == T_DELAY) ? KS_REPEAT : KS_DELAY;
        timer_nxt = (held && timer != T_DELAY) ? timer + 1'b1 : '0;
      end
      KS_REPEAT: begin
        state_nxt = held ? KS_REPEAT : KS_IDLE;
        timer_nxt = (held && timer != T_RATE) ? timer + 1'b1 : '0;
      end
      default:   state_nxt = KS_IDLE;
    endcase
  end
  // repeat FSM output: first press, end of delay, or end of each repeat period
  always_comb begin
    pulse = held && (state == KS_IDLE ||
                     (state == KS_DELAY && timer == T_DELAY) ||
                     (state == KS_REPEAT && timer == T_RATE));
  end
endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: turns raw up/down keys into clean, mutually exclusive inc/dec pulses
module key_conditioner
  import key_pkg::*;
#(
  parameter bit ACTIVE_LOW       = 1'b1,
  parameter int DEBOUNCE_CYC     = 1_000_000,
  parameter int REPEAT_DELAY_CYC = 25_000_000,
  parameter int REPEAT_RATE_CYC  = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic KEY0,
  input  logic KEY1,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic key0_held,
  output logic key1_held
);
  logic up_held, up_pulse, dn_held, dn_pulse;
  key_channel #(
    .ACTIVE_LOW(ACTIVE_LOW), .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC), .REPEAT_RATE_CYC(REPEAT_RATE_CYC)
  ) u_up (.clk(clk), .rst(rst), .raw(KEY0), .held(up_held), .pulse(up_pulse));
  key_channel #(
    .ACTIVE_LOW(ACTIVE_LOW), .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC), .REPEAT_RATE_CYC(REPEAT_RATE_CYC)
  ) u_dn (.clk(clk), .rst(rst), .raw(KEY1), .held(dn_held), .pulse(dn_pulse));
  // output registers; a pulse is suppressed while the opposite key is held
  always_ff @(posedge clk) begin
    if (rst) begin
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
      key0_held <= 1'b0;
      key1_held <= 1'b0;
    end else begin
      inc_pulse <= up_pulse & ~dn_held;
      dec_pulse <= dn_pulse & ~up_held;
      key0_held <= up_held;
      key1_held <= dn_held;
    end
  end
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: table, directed and randomized checks against a behavioural key model
module tb_key_conditioner;
  localparam int D = 4, RD = 10, RR = 3;
  logic clk = 1'b0, rst = 1'b1, KEY0 = 1'b1, KEY1 = 1'b1;
  logic inc_pulse, dec_pulse, key0_held, key1_held;
  int checks = 0, failures = 0;
  int n_inc, n_dec;
  bit s1[2], s2[2], mh[2], mp[2];
  int run[2], age[2];
  bit e_inc, e_dec;
  typedef struct {
    bit r; bit k0; bit k1; int n; int ei; int ed; bit h0; bit h1;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  key_conditioner #(
    .ACTIVE_LOW(1'b1), .DEBOUNCE_CYC(D), .REPEAT_DELAY_CYC(RD), .REPEAT_RATE_CYC(RR)
  ) dut (
    .clk(clk), .rst(rst), .KEY0(KEY0), .KEY1(KEY1),
    .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .key0_held(key0_held), .key1_held(key1_held)
  );

  always @(negedge clk) assert (!(inc_pulse === 1'b1 && dec_pulse === 1'b1))
    else $error("inc_pulse and dec_pulse both high");

  // behavioural model: pressed level delayed two cycles, accepted after D disagreeing
  // cycles, pulses at press age 0, RD+1, then every RR+1 cycles while held
  task automatic model_edge();
    bit pr[2];
    bit old;
    pr[0] = ~KEY0;
    pr[1] = ~KEY1;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        s1[k] = 0; s2[k] = 0; mh[k] = 0; mp[k] = 0; run[k] = 0; age[k] = 0;
      end else begin
        old = mh[k];
        if (s2[k] != mh[k]) begin
          run[k]++;
          if (run[k] == D) begin
            mh[k] = ~mh[k];
            run[k] = 0;
          end
        end else run[k] = 0;
        s2[k] = s1[k];
        s1[k] = pr[k];
        if (mh[k] && !old) begin
          age[k] = 0;
          mp[k] = 1;
        end else if (mh[k]) begin
          age[k]++;
          mp[k] = (age[k] == RD + 1) || (age[k] > RD + 1 && (age[k] - RD - 1) % (RR + 1) == 0);
        end else mp[k] = 0;
      end
    end
    e_inc = mp[0] & ~mh[1];
    e_dec = mp[1] & ~mh[0];
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model{inc,dec,h0,h1}", int'({inc_pulse, dec_pulse, key0_held, key1_held}),
          int'({e_inc, e_dec, mh[0], mh[1]}));
    check("exclusive", int'(inc_pulse & dec_pulse), 0);
    n_inc += int'(inc_pulse);
    n_dec += int'(dec_pulse);
  endtask

  initial begin
    tbl.push_back('{1, 0, 0, 2, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 5, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 1, 1, 0, 1, 0});
    tbl.push_back('{0, 1, 1, 10, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 6, 0, 1, 0, 1});
    tbl.push_back('{0, 1, 0, 10, 0, 0, 0, 1});
    tbl.push_back('{0, 1, 0, 1, 0, 1, 0, 1});
    tbl.push_back('{0, 1, 0, 8, 0, 2, 0, 1});
    tbl.push_back('{0, 1, 1, 5, 0, 1, 0, 1});
    tbl.push_back('{0, 1, 1, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 1, 10, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 6, 1, 0, 1, 0});
    tbl.push_back('{0, 0, 1, 14, 1, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 5, 2, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 12, 0, 0, 1, 1});
    tbl.push_back('{0, 0, 1, 5, 0, 0, 1, 1});
    tbl.push_back('{0, 0, 1, 1, 0, 0, 1, 0});
    tbl.push_back('{0, 0, 1, 4, 1, 0, 1, 0});
    tbl.push_back('{0, 1, 1, 10, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 6, 0, 0, 1, 1});
    tbl.push_back('{0, 1, 1, 8, 0, 0, 0, 0});
    foreach (tbl[i]) begin
      rst = tbl[i].r;
      KEY0 = tbl[i].k0;
      KEY1 = tbl[i].k1;
      n_inc = 0;
      n_dec = 0;
      repeat (tbl[i].n) step();
      check($sformatf("vec%0d inc_count", i), n_inc, tbl[i].ei);
      check($sformatf("vec%0d dec_count", i), n_dec, tbl[i].ed);
      check($sformatf("vec%0d key0_held", i), int'(key0_held), int'(tbl[i].h0));
      check($sformatf("vec%0d key1_held", i), int'(key1_held), int'(tbl[i].h1));
    end
    // bounce: 2-cycle toggles never survive the filter, the settled press does
    n_inc = 0;
    for (int i = 0; i < 10; i++) begin
      KEY0 = i[0];
      repeat (2) step();
    end
    KEY0 = 1'b0;
    repeat (5) step();
    check("bounce_quiet", n_inc, 0);
    check("bounce_held_early", int'(key0_held), 0);
    step();
    check("bounce_pulse", int'(inc_pulse), 1);
    check("bounce_held", int'(key0_held), 1);
    KEY0 = 1'b1;
    repeat (12) step();
    // reset in the middle of a repeat, key still held afterwards
    KEY1 = 1'b0;
    repeat (20) step();
    rst = 1'b1;
    step();
    check("rst_mid_outputs", int'({inc_pulse, dec_pulse, key0_held, key1_held}), 0);
    rst = 1'b0;
    n_dec = 0;
    repeat (5) step();
    check("rst_mid_quiet", n_dec, 0);
    check("rst_mid_held_early", int'(key1_held), 0);
    step();
    check("rst_mid_first_pulse", int'(dec_pulse), 1);
    KEY1 = 1'b1;
    repeat (12) step();
    // randomized key activity with occasional resets
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) step();
        rst = 1'b0;
      end
      KEY0 = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      KEY1 = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      repeat (($urandom_range(0, 4) == 0) ? $urandom_range(15, 45) : $urandom_range(1, 8)) step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
